// File: rtl/road_pkg.sv
// Shared types and constants for the scrolling-road engine: game state
// encoding, LFSR seed/taps and the curvature helper.
package road_pkg;

   // Game state; encoding is visible on the state port
   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_PLAY  = 2'd2,
      ST_CRASH = 2'd3
   } road_state_t;

   // 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1 (right-shifting form)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Map three random bits to a signed edge change: 0..6 -> -3..+3,
   // 7 -> 0, then limit to +/-max_drift.
   function automatic int drift_of(input logic [2:0] sel, input int max_drift);
      int r;
      r = (sel == 3'd7) ? 0 : int'(sel) - 3;
      if (r > max_drift)  r = max_drift;
      if (r < -max_drift) r = -max_drift;
      return r;
   endfunction

endpackage

// File: rtl/road_lfsr.sv
// Curvature source: 16-bit Galois LFSR stepped once per game tick in PLAY.
// Only the low three bits leave the block; they select the drift.
module road_lfsr
   import road_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [2:0] drift_sel
);

   logic [15:0] lfsr;

   // Shift right, folding the tap mask in when a one falls out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (en) begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign drift_sel = lfsr[2:0];

endmodule

// File: rtl/road_scroller.sv
// Scrolling-road engine: ring buffer of per-row left road edges, one-row
// scroll per game tick, player car steering, road-departure detection and
// the INIT/IDLE/PLAY/CRASH game FSM with a saturating score.
// Optional build macro ROAD_CURVE_EN: when defined the road curves using
// LFSR-driven drift; when undefined the road stays straight.
module road_scroller
   import road_pkg::*;
#(
   parameter int ROWS        = 480,
   parameter int XW          = 10,
   parameter int X_MIN       = 144,
   parameter int X_MAX       = 783,
   parameter int X_CENTER    = 464,
   parameter int V_START     = 35,
   parameter int ROAD_HALF   = 50,
   parameter int CAR_HALF    = 5,
   parameter int CAR_Y       = 175,
   parameter int STEP        = 2,
   parameter int MAX_DRIFT   = 3,
   parameter int CRASH_TICKS = 60
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          start,
   input  logic          left,
   input  logic          right,
   input  logic [XW-1:0] hCount,
   input  logic [XW-1:0] vCount,
   input  logic          bright,
   output logic          road_px,
   output logic          car_px,
   output logic          crash,
   output logic [1:0]    state,
   output logic [15:0]   score,
   output logic [XW-1:0] car_x
);

   localparam int AW       = $clog2(ROWS);
   localparam int CW       = $clog2(CRASH_TICKS + 1);
   localparam int ROAD_W   = 2 * ROAD_HALF;
   localparam int EDGE_MAX = X_MAX - ROAD_W;
   localparam int CAR_LO   = X_MIN + CAR_HALF;
   localparam int CAR_HI   = X_MAX - CAR_HALF;

   road_state_t   st, st_next;
   logic [XW-1:0] mem [ROWS];
   logic [AW-1:0] head, head_next, init_addr;
   logic [CW-1:0] crash_cnt;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [XW-1:0] mem_wdata;

   logic          play_tick, hit, init_last, crash_last;
   logic [XW-1:0] car_row_l, top_l, car_next, edge_next;
   int            drift, car_calc, edge_calc;

   logic [XW-1:0] pix_row, pix_l;
   logic          pix_ok, road_hit, car_hit;
   int            dx, dy;

   // (base + off) mod ROWS for off in [0, ROWS)
   function automatic logic [AW-1:0] ring_add(input logic [AW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= ROWS) s = s - ROWS;
      return AW'(s);
   endfunction

   assign play_tick  = (st == ST_PLAY) && tick;
   assign init_last  = (init_addr == AW'(ROWS - 1));
   assign crash_last = (crash_cnt == CW'(CRASH_TICKS - 1));
   assign crash      = (st == ST_CRASH);
   assign state      = st;

`ifdef ROAD_CURVE_EN
   logic [2:0] drift_sel;

   road_lfsr u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .en        (play_tick),
      .drift_sel (drift_sel)
   );

   assign drift = drift_of(drift_sel, MAX_DRIFT);
`else
   assign drift = 0;
`endif

   // Collision edge at the car row and the current top row edge
   assign car_row_l = mem[ring_add(head, CAR_Y)];
   assign top_l     = mem[head];

   // Road departure, car step with clamping, next top-row edge
   always_comb begin
      hit = (int'(car_x) - CAR_HALF < int'(car_row_l)) ||
            (int'(car_x) + CAR_HALF > int'(car_row_l) + ROAD_W);

      car_calc = int'(car_x);
      if (left && !right)      car_calc = car_calc - STEP;
      else if (right && !left) car_calc = car_calc + STEP;
      if (car_calc < CAR_LO)   car_calc = CAR_LO;
      if (car_calc > CAR_HI)   car_calc = CAR_HI;
      car_next = XW'(car_calc);

      edge_calc = int'(top_l) + drift;
      if (edge_calc < X_MIN)    edge_calc = X_MIN;
      if (edge_calc > EDGE_MAX) edge_calc = EDGE_MAX;
      edge_next = XW'(edge_calc);

      head_next = (head == '0) ? AW'(ROWS - 1) : head - AW'(1);
   end

   // Ring-buffer write port: INIT fill or scroll write at the new head
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = init_addr;
      mem_wdata = XW'(X_CENTER - ROAD_HALF);
      if (st == ST_INIT) begin
         mem_we = 1'b1;
      end else if (play_tick && !hit) begin
         mem_we    = 1'b1;
         mem_waddr = head_next;
         mem_wdata = edge_next;
      end
   end

   // Edge memory; a same-cycle read sees the previous contents
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Game FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= ST_INIT;
      else     st <= st_next;
   end

   // Game FSM next-state logic; a tick arriving with start in IDLE is dropped
   always_comb begin
      st_next = st;
      case (st)
         ST_INIT:  if (init_last) st_next = ST_IDLE;
         ST_IDLE:  if (start) st_next = ST_PLAY;
         ST_PLAY:  if (tick && hit) st_next = ST_CRASH;
         ST_CRASH: if (tick && crash_last) st_next = ST_INIT;
         default:  st_next = ST_INIT;
      endcase
   end

   // Game datapath: fill pointer, scroll head, car position, score, crash timer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_addr <= '0;
         head      <= '0;
         car_x     <= XW'(X_CENTER);
         score     <= '0;
         crash_cnt <= '0;
      end else begin
         case (st)
            ST_INIT: begin
               head      <= '0;
               car_x     <= XW'(X_CENTER);
               crash_cnt <= '0;
               init_addr <= init_last ? '0 : init_addr + AW'(1);
            end
            ST_IDLE: begin
               if (start) score <= '0;
            end
            ST_PLAY: begin
               if (tick && !hit) begin
                  score <= (score == 16'hFFFF) ? score : score + 16'd1;
                  car_x <= car_next;
                  head  <= head_next;
               end
            end
            ST_CRASH: begin
               if (tick) crash_cnt <= crash_last ? '0 : crash_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Pixel classification for the current beam position
   always_comb begin
      pix_row  = vCount - XW'(V_START);
      pix_ok   = bright && (int'(vCount) >= V_START) && (int'(pix_row) < ROWS);
      pix_l    = mem[ring_add(head, pix_ok ? int'(pix_row) : 0)];
      road_hit = (int'(hCount) >= int'(pix_l)) &&
                 (int'(hCount) <= int'(pix_l) + ROAD_W);
      dx       = int'(hCount) - int'(car_x);
      dy       = int'(pix_row) - CAR_Y;
      car_hit  = (dx >= -CAR_HALF) && (dx <= CAR_HALF) &&
                 (dy >= -CAR_HALF) && (dy <= CAR_HALF);
   end

   // Registered pixel outputs, one cycle behind the beam inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         road_px <= 1'b0;
         car_px  <= 1'b0;
      end else begin
         road_px <= pix_ok && road_hit;
         car_px  <= pix_ok && car_hit;
      end
   end

endmodule

// File: doc/road_scroller.md
# road_scroller

Parametrised scrolling-road engine for the stay-on-road VGA game: holds per-row road edges in a ring buffer, scrolls the road one row per game tick with LFSR-driven curvature, moves the player car, detects road departure and runs a small game FSM with score. Sits between the VGA timing generator (`hCount`/`vCount`/`bright`) and the colour mux, which turns `road_px`/`car_px` into RGB.

## Interface
Parameters:
- `ROWS`, 480: visible rows; ring-buffer depth.
- `XW`, 10: coordinate width.
- `X_MIN`, 144: leftmost visible `hCount`.
- `X_MAX`, 783: rightmost visible `hCount`.
- `X_CENTER`, 464: initial road/car centre.
- `V_START`, 35: first visible `vCount`.
- `ROAD_HALF`, 50: half road width.
- `CAR_HALF`, 5: half car size.
- `CAR_Y`, 175: car screen row (0-based).
- `STEP`, 2: car x step per tick.
- `MAX_DRIFT`, 3: max edge change per row (≤3).
- `CRASH_TICKS`, 60: ticks held in CRASH.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `tick` in 1: one-cycle game-step strobe.
- `start` in 1: level; begins play from IDLE.
- `left`, `right` in 1 each: steering.
- `hCount`, `vCount` in XW: current pixel.
- `bright` in 1: visible-area flag.
- `road_px` out 1: pixel is road (registered).
- `car_px` out 1: pixel is car (registered).
- `crash` out 1: high while in CRASH.
- `state` out 2: INIT=0, IDLE=1, PLAY=2, CRASH=3.
- `score` out 16: ticks survived.
- `car_x` out XW: car centre.

## Operation
- Buffer stores left edge only; right edge = left + 2·ROAD_HALF. Screen row r reads `mem[(head + r) mod ROWS]`.
- INIT: write `X_CENTER-ROAD_HALF` to address 0..ROWS-1, one per `clk`; `head`=0, `car_x`=X_CENTER; then IDLE. `tick`, `start` ignored.
- IDLE: `start`=1 → PLAY, clear `score`.
- PLAY, per `tick`:
  - Collision first, using current `car_x` and row CAR_Y edges: crash if `car_x-CAR_HALF < L` or `car_x+CAR_HALF > L+2·ROAD_HALF` → CRASH, no move, no score.
  - Else: `score` += 1 (saturate 0xFFFF); car moves −STEP (`left` only) / +STEP (`right` only) / none (both or neither), clamped to [X_MIN+CAR_HALF, X_MAX−CAR_HALF].
  - Scroll: `head` ← `head`−1 mod ROWS (wrap 0→ROWS−1); new top row written = old top + drift, clamped to [X_MIN, X_MAX−2·ROAD_HALF].
- Drift: d = LFSR[2:0]; d∈0..6 → d−3, d=7 → 0; result clamped to ±MAX_DRIFT.
- CRASH: count CRASH_TICKS ticks, then INIT (road regenerates). `score` held until next PLAY entry.
- Pixel path: row = `vCount−V_START`; outside [0,ROWS) or `bright`=0 → both outputs 0. `road_px` = L ≤ `hCount` ≤ L+2·ROAD_HALF; `car_px` = |`hCount−car_x`| ≤ CAR_HALF and |row−CAR_Y| ≤ CAR_HALF. `car_px` has priority at mux; both may be 1.

## Timing
- Reset (async, immediate): `road_px`=0, `car_px`=0, `crash`=0, `state`=INIT, `score`=0, `car_x`=X_CENTER, `head`=0, LFSR=0xACE1.
- INIT lasts exactly ROWS cycles; `state`=IDLE on cycle ROWS after reset release.
- Pixel outputs: 1-cycle latency from `hCount`/`vCount`/`bright`.
- Tick effects (state, score, car_x, head) visible cycle after `tick`.
- `tick` and `start` together in IDLE: enter PLAY only; tick not consumed.
- `rst` mid-PLAY/CRASH: immediate return to reset values, INIT restarts.
- Scroll write and display read same address same cycle: read returns old value.

## Configuration
- `ROAD_CURVE_EN` defined: LFSR drift as above.
- Undefined: drift forced 0, LFSR not instantiated; road stays straight at X_CENTER±ROAD_HALF.

## Structure
- `road_pkg`: state enum (INIT/IDLE/PLAY/CRASH), LFSR seed 0xACE1, taps.
- Sub-module `road_lfsr`: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advances on `tick` in PLAY.

## Test plan
- Release reset → `state`=0 for 480 cycles, 1 at cycle 480; `road_px`=1 for `hCount` 414..514 on every row, 0 at 413/515.
- No curve, `start`, 100 ticks, no steering → `crash`=0, `score`=100, `car_x`=464.
- Hold `right`, tick repeatedly → `car_x`=510 after 23 ticks; 24th tick → `crash`=1, `state`=3, `score`=23, `car_x` stays 510.
- In CRASH, 60 ticks → `state`=0, 480 cycles later `state`=1, edges back at 414.
- `ROAD_CURVE_EN`, 1000 ticks with car steered to centre of row CAR_Y → adjacent-row edge deltas within ±3, all edges in [144, 683], `head` wraps 0→479.
- Assert `rst` mid-PLAY between clock edges → all outputs at reset values before next `clk` edge.
